// File: rtl/load_store_sequencer_pkg.sv
// Shared opcode/funct3 constants, FSM state type and the alignment helper
// for the load/store sequencer.
package load_store_sequencer_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Byte-offset bits that survive natural alignment for an access size
  // given as funct3[1:0] (0=byte .. 3=doubleword).
  function automatic logic [2:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b111;
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Request/response and data-memory signals of the load/store sequencer.
// slave = sequencer side, master = control unit plus data memory side.
interface load_store_sequencer_if;

  logic        start;
  logic [31:0] instr;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic        busy;
  logic        done;
  logic [63:0] load_data;
  logic        err;

  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  start, instr, addr, store_data, mem_rdata,
    output busy, done, load_data, err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output start, instr, addr, store_data, mem_rdata,
    input  busy, done, load_data, err, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/load_store_sequencer_lane_extract_merge.sv
// Combinational lane logic: load byte-lane shift with sign/zero extension,
// and store byte-merge of rs2 low bytes into the captured doubleword.
module load_store_sequencer_lane_extract_merge
  import load_store_sequencer_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [63:0] mdr,
  input  logic [63:0] store_data,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] load_ext,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] lane_data;
  logic [7:0]  byte_en;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    load_ext = shifted;
    case (funct3)
      F3_B:    load_ext = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    load_ext = shifted;
      F3_BU:   load_ext = {56'd0, shifted[7:0]};
      F3_HU:   load_ext = {48'd0, shifted[15:0]};
      F3_WU:   load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // sd is the full-width case of the merge: all eight lanes come from rs2.
  always_comb begin
    case (funct3[1:0])
      2'd0:    byte_en = 8'h01 << offset;
      2'd1:    byte_en = 8'h03 << offset;
      2'd2:    byte_en = 8'h0F << offset;
      default: byte_en = 8'hFF;
    endcase
    lane_data = store_data << {offset, 3'b000};
    merged    = mdr;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer against a 64-bit data memory port.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int MEM_LATENCY = 1
)(
  input logic                   clk,
  input logic                   reset_n,
  load_store_sequencer_if.slave bus
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic        req_load;
  logic [2:0]  req_f3;
  logic [2:0]  req_off;
  logic [63:0] req_sdata;
  logic [63:0] mem_addr_q;
  logic [63:0] mdr;
  logic [63:0] load_data_q;
  logic        err_q;
  logic [63:0] load_ext;
  logic [63:0] merged;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        load_ok;
  logic        store_ok;
  logic        illegal;
  logic [2:0]  acc_off;
  logic        unused_instr;

  assign opc      = bus.instr[6:0];
  assign f3       = bus.instr[14:12];
  assign load_ok  = (opc == OPC_LOAD) && (f3 != 3'b111);
  assign store_ok = (opc == OPC_STORE) && !f3[2];
  assign acc_off  = bus.addr[2:0] & lane_mask(f3[1:0]);
  assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};

`ifdef MISALIGN_TRAP_EN
  // Any offset bit removed by alignment means the access was misaligned.
  assign illegal = !(load_ok || store_ok) || (acc_off != bus.addr[2:0]);
`else
  assign illegal = !(load_ok || store_ok);
`endif

  load_store_sequencer_lane_extract_merge u_lane_extract_merge (
    .rdata      (bus.mem_rdata),
    .mdr        (mdr),
    .store_data (req_sdata),
    .offset     (req_off),
    .funct3     (req_f3),
    .load_ext   (load_ext),
    .merged     (merged)
  );

  // NOTE: reset is synchronous: reset_n is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (illegal)                       state_nxt = ST_DONE;
          else if (store_ok && f3 == F3_D)   state_nxt = ST_WRITE;
          else                               state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == 3'd1) state_nxt = req_load ? ST_DONE : ST_WRITE;
      ST_WRITE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      req_load    <= 1'b0;
      req_f3      <= '0;
      req_off     <= '0;
      req_sdata   <= '0;
      mem_addr_q  <= '0;
      mdr         <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        req_load   <= load_ok && !illegal;
        req_f3     <= f3;
        req_off    <= acc_off;
        req_sdata  <= bus.store_data;
        mem_addr_q <= {bus.addr[63:3], 3'b000};
        err_q      <= illegal;
      end
      if (state == ST_READ)      cnt <= LAT;
      else if (state == ST_WAIT) cnt <= cnt - 3'd1;
      // Extraction reads mem_rdata directly so load_data is ready with done.
      if (state == ST_WAIT && cnt == 3'd1) begin
        mdr <= bus.mem_rdata;
        if (req_load) load_data_q <= load_ext;
      end
    end
  end

  assign bus.mem_read  = (state == ST_READ);
  assign bus.mem_write = (state == ST_WRITE);
  assign bus.done      = (state == ST_DONE);
  assign bus.busy      = (state == ST_READ) || (state == ST_WAIT) || (state == ST_WRITE);
  assign bus.err       = (state == ST_DONE) && err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = merged;
  assign bus.load_data = load_data_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: per-request timeline model checked every
// cycle, directed vectors with literal expectations, and a latency-3 instance.
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

  localparam int          LAT1    = 1;
  localparam int          LAT3    = 3;
  localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  load_store_sequencer_if bus();
  load_store_sequencer_if b3();

  load_store_sequencer #(.MEM_LATENCY(LAT1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  load_store_sequencer #(.MEM_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  // Memory responders: data is valid exactly LAT cycles after a read strobe.
  logic [63:0] mem_word = '0;
  logic [63:0] word3    = '0;
  logic [7:0]  hist1    = '0;
  logic [7:0]  hist3    = '0;
  always @(negedge clk) begin
    hist1 = {hist1[6:0], bus.mem_read};
    bus.mem_rdata = hist1[LAT1] ? mem_word : GARBAGE;
    hist3 = {hist3[6:0], b3.mem_read};
    b3.mem_rdata = hist3[LAT3] ? word3 : GARBAGE;
  end

  // Model: one request at a time, described by its cycle offsets from accept.
  bit          model_on = 1'b0;
  bit          active   = 1'b0;
  int          k, done_k, read_k, write_k;
  bit          m_is_load, m_err;
  logic [63:0] m_ld, m_wdata;
  logic [63:0] exp_addr = '0;
  logic [63:0] exp_ld   = '0;
  int          n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0, acc_cyc = 0;
  logic [63:0] last_wdata = '0;

  task automatic model_accept();
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          size, o, oa;
    bit          is_ld, is_st, bad;
    logic [7:0]  wb [8];
    logic [63:0] v;
    opc   = bus.instr[6:0];
    f3    = bus.instr[14:12];
    size  = 1 << int'(f3[1:0]);
    is_ld = (opc == 7'b0000011) && (f3 != 3'd7);
    is_st = (opc == 7'b0100011) && (f3 <= 3'd3);
    o     = int'(bus.addr[2:0]);
    oa    = o - (o % size);
`ifdef MISALIGN_TRAP_EN
    bad = !(is_ld || is_st) || ((o % size) != 0);
`else
    bad = !(is_ld || is_st);
`endif
    for (int i = 0; i < 8; i++) wb[i] = mem_word[8*i +: 8];
    v = '0;
    for (int n = 0; n < size; n++) v = v | (64'(wb[oa+n]) << (8*n));
    if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
    m_ld = v;
    for (int n = 0; n < size; n++) wb[oa+n] = bus.store_data[8*n +: 8];
    for (int i = 0; i < 8; i++) m_wdata[8*i +: 8] = wb[i];
    exp_addr  = {bus.addr[63:3], 3'b000};
    m_err     = bad;
    m_is_load = is_ld && !bad;
    active = 1'b1; k = 1; read_k = 0; write_k = 0;
    if (bad)             done_k = 1;
    else if (is_ld)      begin read_k = 1; done_k = 2 + LAT1; end
    else if (f3 == 3'd3) begin write_k = 1; done_k = 2; end
    else                 begin read_k = 1; write_k = 2 + LAT1; done_k = 3 + LAT1; end
  endtask

  bit e_done, e_busy, e_rd, e_wr;
  always @(negedge clk) begin
    if (model_on) begin
      e_done = active && (k == done_k);
      e_busy = active && (k < done_k);
      e_rd   = active && (k == read_k);
      e_wr   = active && (k == write_k);
      check("done",      bus.done,      e_done);
      check("busy",      bus.busy,      e_busy);
      check("err",       bus.err,       e_done && m_err);
      check("mem_read",  bus.mem_read,  e_rd);
      check("mem_write", bus.mem_write, e_wr);
      check("mem_addr",  bus.mem_addr,  exp_addr);
      check("load_data", bus.load_data, exp_ld);
      if (e_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
      if (bus.mem_read)  begin n_rd++; rd_cyc = cyc; end
      if (bus.mem_write) begin n_wr++; wr_cyc = cyc; last_wdata = bus.mem_wdata; end
    end
    if (!reset_n) begin
      model_on = 1'b1; active = 1'b0; exp_addr = '0; exp_ld = '0;
    end else if (model_on) begin
      if (active && k == done_k) active = 1'b0;
      else if (active) begin
        k++;
        if (k == done_k && m_is_load) exp_ld = m_ld;
      end else if (bus.start) model_accept();
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] sd,
                       input logic [63:0] word, input bit poke, output int lat, output logic e);
    @(posedge clk); #1;
    mem_word = word; bus.instr = ins; bus.addr = a; bus.store_data = sd; bus.start = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.instr = 32'h0000_0013; bus.addr = '1; bus.store_data = '1;
    if (poke) begin bus.start = 1'b1; bus.instr = mk(F3_D, OPC_STORE); end
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    e = bus.err;
    check("done_seen", bus.done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   lat, rd0, wr0, nrd3;
  logic e;
  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.instr = '0; bus.addr = '0; bus.store_data = '0; bus.mem_rdata = '0;
    b3.start  = 1'b0; b3.instr  = '0; b3.addr  = '0; b3.store_data  = '0; b3.mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_busy",      bus.busy,      1'b0);
    check("reset_load_data", bus.load_data, 64'h0);
    check("reset_mem_addr",  bus.mem_addr,  64'h0);

    // lb of a negative byte in lane 3
    issue(mk(F3_B, OPC_LOAD), 64'h1003, 64'h0, 64'h00000000_80FF0000, 1'b0, lat, e);
    check("lb_latency",     64'(lat), 64'd3);
    check("lb_read_offset", 64'(rd_cyc - acc_cyc), 64'd1);
    check("lb_data",        bus.load_data, 64'hFFFFFFFF_FFFFFF80);
    check("lb_err",         e, 1'b0);

    issue(mk(F3_WU, OPC_LOAD), 64'h2004, 64'h0, 64'h9ABCDEF0_00000000, 1'b0, lat, e);
    check("lwu_data", bus.load_data, 64'h00000000_9ABCDEF0);
    issue(mk(F3_W, OPC_LOAD), 64'h2004, 64'h0, 64'h9ABCDEF0_00000000, 1'b0, lat, e);
    check("lw_data",  bus.load_data, 64'hFFFFFFFF_9ABCDEF0);

    // sh read-modify-write
    rd0 = n_rd; wr0 = n_wr;
    issue(mk(F3_H, OPC_STORE), 64'h3002, 64'h1234, 64'h11111111_11111111, 1'b0, lat, e);
    check("sh_latency",  64'(lat), 64'd4);
    check("sh_wdata",    last_wdata, 64'h11111111_12341111);
    check("sh_mem_addr", bus.mem_addr, 64'h3000);
    check("sh_reads",    64'(n_rd - rd0), 64'd1);
    check("sh_writes",   64'(n_wr - wr0), 64'd1);
    check("sh_load_kept", bus.load_data, 64'hFFFFFFFF_9ABCDEF0);

    // sb into the top lane; only the low byte of rs2 may land
    issue(mk(F3_B, OPC_STORE), 64'h3007, 64'hFFFFFFFF_FFFFFFAB, 64'h11111111_11111111, 1'b0, lat, e);
    check("sb_wdata", last_wdata, 64'hAB111111_11111111);

    // sd direct write
    rd0 = n_rd; wr0 = n_wr;
    issue(mk(F3_D, OPC_STORE), 64'h4000, 64'hDEADBEEF_CAFEF00D, 64'h55555555_55555555, 1'b0, lat, e);
    check("sd_latency",      64'(lat), 64'd2);
    check("sd_write_offset", 64'(wr_cyc - acc_cyc), 64'd1);
    check("sd_wdata",        last_wdata, 64'hDEADBEEF_CAFEF00D);
    check("sd_reads",        64'(n_rd - rd0), 64'd0);

    // illegal funct3 and illegal opcode
    rd0 = n_rd; wr0 = n_wr;
    issue(mk(3'b111, OPC_LOAD), 64'h1000, 64'h0, 64'h0, 1'b0, lat, e);
    check("illf3_latency", 64'(lat), 64'd1);
    check("illf3_err",     e, 1'b1);
    check("illf3_strobes", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);
    check("illf3_load_kept", bus.load_data, 64'hFFFFFFFF_9ABCDEF0);
    issue(mk(3'b010, 7'b0110011), 64'h1000, 64'h0, 64'h0, 1'b0, lat, e);
    check("illopc_err", e, 1'b1);

    // start while busy is ignored
    wr0 = n_wr;
    issue(mk(F3_BU, OPC_LOAD), 64'h1002, 64'h0, 64'h00000000_80FF0000, 1'b1, lat, e);
    check("poke_latency", 64'(lat), 64'd3);
    check("poke_writes",  64'(n_wr - wr0), 64'd0);
    check("lbu_data",     bus.load_data, 64'h00000000_000000FF);

    issue(mk(F3_HU, OPC_LOAD), 64'h10006, 64'h0, 64'hFFFE0000_00000000, 1'b0, lat, e);
    check("lhu_data", bus.load_data, 64'h00000000_0000FFFE);

    // reset during WAIT
    @(posedge clk); #1;
    mem_word = 64'h01020304_05060708;
    bus.instr = mk(F3_D, OPC_LOAD); bus.addr = 64'h7000; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_busy",      bus.busy,      1'b0);
    check("abort_done",      bus.done,      1'b0);
    check("abort_strobes",   {bus.mem_read, bus.mem_write}, 2'b00);
    check("abort_load_data", bus.load_data, 64'h0);
    check("abort_mem_addr",  bus.mem_addr,  64'h0);

    // misaligned lw
    rd0 = n_rd;
    issue(mk(F3_W, OPC_LOAD), 64'h5002, 64'h0, 64'h88776655_44332211, 1'b0, lat, e);
`ifdef MISALIGN_TRAP_EN
    check("mis_err",       e, 1'b1);
    check("mis_latency",   64'(lat), 64'd1);
    check("mis_reads",     64'(n_rd - rd0), 64'd0);
    check("mis_load_kept", bus.load_data, 64'h0);
`else
    check("mis_err",     e, 1'b0);
    check("mis_latency", 64'(lat), 64'd3);
    check("mis_data",    bus.load_data, 64'h00000000_44332211);
`endif

    // ld on the latency-3 instance
    @(posedge clk); #1;
    word3 = 64'h01234567_89ABCDEF;
    b3.instr = mk(F3_D, OPC_LOAD); b3.addr = 64'h6008; b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    lat = 1; nrd3 = int'(b3.mem_read);
    while (!b3.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      nrd3 += int'(b3.mem_read);
    end
    check("lat3_latency", 64'(lat), 64'd5);
    check("lat3_data",    b3.load_data, 64'h01234567_89ABCDEF);
    check("lat3_err",     b3.err, 1'b0);
    check("lat3_reads",   64'(nrd3), 64'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Multicycle controller that sequences one load or store per request against a single 64-bit doubleword-wide data memory port.
- Loads: issues the read, waits for memory, captures the doubleword, lane-selects and sign/zero-extends per funct3, returns a 64-bit result.
- Sub-doubleword stores: read-modify-write. sd: direct write.
- Sits between the main control unit (start/done handshake) and the data memory.

Parameters:
- MEM_LATENCY, 1, cycles from mem_read asserted to mem_rdata valid; legal 1..7.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- start  in  1  request strobe; accepted only when busy=0
- instr  in  32  instruction; uses [6:0] opcode, [14:12] funct3
- addr  in  64  effective byte address
- store_data  in  64  rs2 value for stores
- mem_addr  out  64  doubleword address {addr[63:3],3'b000}
- mem_read  out  1  read strobe, one cycle
- mem_write  out  1  write strobe, one cycle
- mem_wdata  out  64  write data
- mem_rdata  in  64  read data, valid MEM_LATENCY cycles after mem_read
- busy  out  1  request in flight
- done  out  1  one-cycle completion pulse
- load_data  out  64  extended load result, valid and held from done until next accept
- err  out  1  valid with done; illegal opcode/funct3 or misaligned (see option)

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; busy, done, err, mem_read, mem_write = 0; mem_addr, mem_wdata, load_data = 0; latency counter = 0. Reset mid-operation aborts immediately; no strobe is asserted in the following cycle.
- Request (instr, addr, store_data) registered on accept; inputs may change afterwards.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: start=1 -> register request, busy=1.
  - Load (0000011) with funct3 in {000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu} -> READ.
  - Store (0100011): funct3 011 sd -> WRITE; {000 sb, 001 sh, 010 sw} -> READ.
  - Any other opcode/funct3 -> DONE with err=1; no memory access.
- READ: mem_read=1 for exactly one cycle; counter loaded with MEM_LATENCY -> WAIT.
- WAIT: counter decrements each cycle. When counter reaches 1, mem_rdata is captured into an internal mdr register on that edge.
  - Load -> DONE.
  - Store -> WRITE.
- WRITE: mem_write=1 for one cycle.
  - sd: mem_wdata=store_data.
  - Others: mem_wdata = mdr with the selected bytes replaced by store_data low bytes shifted to lane addr[2:0]*8.
  - Then -> DONE.
- DONE: done=1 and busy=0 for one cycle -> IDLE. start in DONE is ignored. err is valid only while done=1.
- Load extension: shifted = mdr >> (addr[2:0]*8).
  - b/h/w: sign-extend from bit 7/15/31 of shifted.
  - bu/hu/wu: zero-extend.
  - ld: full 64 bits.
  - load_data is written only on load completion; stores and errors leave it unchanged.
- Latency from the accept edge to done=1:
  - Load / sub-doubleword store: 2+MEM_LATENCY cycles for loads, 3+MEM_LATENCY for RMW stores.
  - sd: 2 cycles.
  - Illegal: 1 cycle.
- mem_read and mem_write never assert in the same cycle. mem_addr is held constant from accept until DONE.
- start while busy=1 is ignored (not queued).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: access not naturally aligned (h: addr[0]≠0; w: addr[1:0]≠0; d: addr[2:0]≠0) goes IDLE -> DONE with err=1; no memory strobe; load_data unchanged.
- Undefined: low address bits beyond the access size are forced to zero (aligned down); err is never set by alignment.

Decomposition:
- Shared package: opcode constants (OPC_LOAD, OPC_STORE), funct3 constants for each width, and the state enum typedef.
- One natural sub-module, lane_extract_merge (combinational):
  - Load lane shift + sign/zero extend.
  - Store byte-merge.
  - Keeps the FSM file purely sequential.

Test Plan:
- lb, addr=0x1003, mem_rdata=0x00000000_80FF0000 (byte3=0x80), MEM_LATENCY=1 -> mem_read at accept+1, done at accept+3, load_data=0xFFFFFFFF_FFFFFF80, err=0.
- lwu, addr=0x2004, mem_rdata=0x9ABCDEF0_00000000 -> load_data=0x00000000_9ABCDEF0; same with lw -> 0xFFFFFFFF_9ABCDEF0.
- sh, addr=0x3002, store_data=0x1234, mem_rdata=0x11111111_11111111 -> one mem_read then one mem_write, mem_wdata=0x11111111_12341111, mem_addr=0x3000.
- sd, addr=0x4000, store_data=0xDEADBEEF_CAFEF00D -> no mem_read, mem_write at accept+1, done at accept+2.
- Illegal funct3=111 load -> done at accept+1, err=1, no strobes; start pulsed while busy ignored; reset_n=0 during WAIT -> IDLE, all outputs 0 next cycle.
- MEM_LATENCY=3 ld -> done at accept+5. With MISALIGN_TRAP_EN, lw at 0x5002 -> err=1, no memory access.
